// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mdu_ctrl
// Description : HI/LO control for a multiply/divide unit. Launches operations
//               on an external fully pipelined multiplier (2-cycle latency)
//               and an external iterative divider. Tracks in-flight
//               multiplies in a two-stage valid pipeline and retires results
//               into the HI/LO architectural registers.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               flush_i                    - kill all in-flight work
//               op_valid_i, op_i, opr1_i,
//               opr2_i                     - operation request and operands
//               op_ready_o                 - request can be accepted
//               mul_*                      - multiplier launch / result
//               div_*                      - divider launch / cancel / result
//               hi_o, lo_o                 - HI/LO register contents
//               mdu_is_active              - any operation in flight
//               mdu_div_active             - divide in flight
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        op_valid_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] opr1_i,
  input  logic [31:0] opr2_i,
  output logic        mul_start_o,
  output logic        mul_signed_o,
  output logic [31:0] mul_a_o,
  output logic [31:0] mul_b_o,
  input  logic [63:0] mul_res_i,
  output logic        div_start_o,
  output logic        div_signed_o,
  output logic [31:0] div_a_o,
  output logic [31:0] div_b_o,
  output logic        div_cancel_o,
  input  logic        div_done_i,
  input  logic [31:0] div_quot_i,
  input  logic [31:0] div_rem_i,
  output logic        op_ready_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        mdu_is_active,
  output logic        mdu_div_active
);

  localparam logic [2:0] c_OP_MULT  = 3'd1;
  localparam logic [2:0] c_OP_MULTU = 3'd2;
  localparam logic [2:0] c_OP_DIV   = 3'd3;
  localparam logic [2:0] c_OP_DIVU  = 3'd4;
  localparam logic [2:0] c_OP_MTHI  = 3'd5;
  localparam logic [2:0] c_OP_MTLO  = 3'd6;

  typedef enum logic [0:0] {
    S_IDLE     = 1'b0,
    S_DIV_WAIT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_pv1_v, r_pv1_whi, r_pv1_wlo;
  logic        r_pv2_v, r_pv2_whi, r_pv2_wlo;
  logic [31:0] r_hi, r_lo;

  logic        w_is_mul, w_is_div, w_pv_any;
  logic        w_accept;
  logic        w_acc_mul, w_acc_mthi, w_acc_mtlo;
  logic        w_div_done;

  assign w_is_mul = (op_i == c_OP_MULT) || (op_i == c_OP_MULTU);
  assign w_is_div = (op_i == c_OP_DIV)  || (op_i == c_OP_DIVU);
  assign w_pv_any = r_pv1_v | r_pv2_v;

  // ---------------------------------------------------------------------------
  // Divide FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Divide FSM: next state, handshake and launch outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    op_ready_o   = 1'b0;
    div_cancel_o = 1'b0;
    w_div_done   = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        // A divide writes both halves directly, so it must not overtake
        // multiply results still travelling through the tracker.
        op_ready_o = ~(w_is_div & w_pv_any);
      end
      S_DIV_WAIT: begin
        if (flush_i) begin
          div_cancel_o = 1'b1;
          w_state_nxt  = S_IDLE;
        end else if (div_done_i) begin
          w_div_done  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_accept = op_valid_i & op_ready_o & ~flush_i;
    if (w_accept && w_is_div) begin
      w_state_nxt = S_DIV_WAIT;
    end
  end

  assign w_acc_mul  = w_accept & w_is_mul;
  assign w_acc_mthi = w_accept & (op_i == c_OP_MTHI);
  assign w_acc_mtlo = w_accept & (op_i == c_OP_MTLO);

  // Launch strobes are qualified with rst_n so nothing is started while the
  // block is held in reset.
  assign mul_start_o  = w_acc_mul & rst_n;
  assign mul_signed_o = (op_i == c_OP_MULT);
  assign mul_a_o      = opr1_i;
  assign mul_b_o      = opr2_i;

  assign div_start_o  = w_accept & w_is_div & rst_n;
  assign div_signed_o = (op_i == c_OP_DIV);
  assign div_a_o      = opr1_i;
  assign div_b_o      = opr2_i;

  // ---------------------------------------------------------------------------
  // Multiply tracker: pv1 = launched last cycle, pv2 = result on mul_res_i now
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pv1_v   <= 1'b0;
      r_pv1_whi <= 1'b0;
      r_pv1_wlo <= 1'b0;
      r_pv2_v   <= 1'b0;
      r_pv2_whi <= 1'b0;
      r_pv2_wlo <= 1'b0;
    end else begin
      r_pv1_v   <= w_acc_mul;
      r_pv1_whi <= w_acc_mul;
      r_pv1_wlo <= w_acc_mul;
      // A younger MT* supersedes the older multiply's write to that half.
      r_pv2_v   <= r_pv1_v   & ~flush_i;
      r_pv2_whi <= r_pv1_whi & ~flush_i & ~w_acc_mthi;
      r_pv2_wlo <= r_pv1_wlo & ~flush_i & ~w_acc_mtlo;
    end
  end

  // ---------------------------------------------------------------------------
  // HI/LO registers; MT* is assigned last so it wins over a coincident
  // multiply retirement.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else begin
      if (w_div_done) begin
        r_hi <= div_rem_i;
        r_lo <= div_quot_i;
      end else if (r_pv2_v && !flush_i) begin
        if (r_pv2_whi) r_hi <= mul_res_i[63:32];
        if (r_pv2_wlo) r_lo <= mul_res_i[31:0];
      end
      if (w_acc_mthi) r_hi <= opr1_i;
      if (w_acc_mtlo) r_lo <= opr1_i;
    end
  end

  assign hi_o           = r_hi;
  assign lo_o           = r_lo;
  assign mdu_div_active = (r_state == S_DIV_WAIT);
  assign mdu_is_active  = w_pv_any | (r_state == S_DIV_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_ctrl
// Description : Self-checking bench for mdu_ctrl. Directed scenarios followed
//               by random traffic, all checked cycle by cycle against a
//               transaction-level model of HI/LO and pending results.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i, op_valid_i;
  logic [2:0]  op_i;
  logic [31:0] opr1_i, opr2_i;
  logic        mul_start_o, mul_signed_o;
  logic [31:0] mul_a_o, mul_b_o;
  logic [63:0] mul_res_i;
  logic        div_start_o, div_signed_o, div_cancel_o;
  logic [31:0] div_a_o, div_b_o;
  logic        div_done_i;
  logic [31:0] div_quot_i, div_rem_i;
  logic        op_ready_o;
  logic [31:0] hi_o, lo_o;
  logic        mdu_is_active, mdu_div_active;

  always #5 clk = ~clk;

  mdu_ctrl dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .op_valid_i(op_valid_i),
    .op_i(op_i), .opr1_i(opr1_i), .opr2_i(opr2_i),
    .mul_start_o(mul_start_o), .mul_signed_o(mul_signed_o),
    .mul_a_o(mul_a_o), .mul_b_o(mul_b_o), .mul_res_i(mul_res_i),
    .div_start_o(div_start_o), .div_signed_o(div_signed_o),
    .div_a_o(div_a_o), .div_b_o(div_b_o), .div_cancel_o(div_cancel_o),
    .div_done_i(div_done_i), .div_quot_i(div_quot_i), .div_rem_i(div_rem_i),
    .op_ready_o(op_ready_o), .hi_o(hi_o), .lo_o(lo_o),
    .mdu_is_active(mdu_is_active), .mdu_div_active(mdu_div_active)
  );

  // Reference model: architectural HI/LO plus a list of multiply results
  // that will be written at a known future cycle.
  typedef struct {
    int          due;
    logic [63:0] res;
    bit          whi;
    bit          wlo;
  } pend_t;

  pend_t       m_q[$];
  logic [31:0] m_hi, m_lo;
  bit          m_busy;
  int          cyc;
  logic        last_ready, last_div_start;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] product(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    if (op == 3'd1) begin
      sa = $signed({{32{a[31]}}, a});
      sb = $signed({{32{b[31]}}, b});
      return sa * sb;
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  // One clock cycle: apply inputs, check outputs mid-cycle, update the model.
  task automatic cycle(input bit v, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit fl, input bit dd,
                       input logic [31:0] qt, input logic [31:0] rm, input bit rn);
    bit is_mul, is_div, ready, acc, due;
    rst_n = rn; op_valid_i = v; op_i = op; opr1_i = a; opr2_i = b;
    flush_i = fl; div_done_i = dd; div_quot_i = qt; div_rem_i = rm;
    if (!rn) begin
      m_hi = 32'd0; m_lo = 32'd0; m_busy = 1'b0; m_q.delete();
    end
    due       = (m_q.size() > 0) && (m_q[0].due == cyc);
    mul_res_i = due ? m_q[0].res : {$urandom, $urandom};
    is_mul    = (op == 3'd1) || (op == 3'd2);
    is_div    = (op == 3'd3) || (op == 3'd4);
    ready     = !m_busy && !(is_div && m_q.size() > 0);
    acc       = rn && v && ready && !fl;

    @(negedge clk);
    last_ready     = op_ready_o;
    last_div_start = div_start_o;
    check("op_ready",    op_ready_o,     ready);
    check("mul_start",   mul_start_o,    acc && is_mul);
    check("div_start",   div_start_o,    acc && is_div);
    check("div_cancel",  div_cancel_o,   m_busy && fl);
    check("is_active",   mdu_is_active,  (m_q.size() > 0) || m_busy);
    check("div_active",  mdu_div_active, m_busy);
    check("hi",          hi_o,           m_hi);
    check("lo",          lo_o,           m_lo);
    check("mul_a",       mul_a_o,        a);
    check("mul_b",       mul_b_o,        b);
    check("div_a",       div_a_o,        a);
    check("div_b",       div_b_o,        b);
    if (acc && is_mul) check("mul_signed", mul_signed_o, op == 3'd1);
    if (acc && is_div) check("div_signed", div_signed_o, op == 3'd3);

    @(posedge clk);
    if (rn) begin
      if (fl) begin
        m_q.delete();
        m_busy = 1'b0;
      end else begin
        if (due) begin
          if (m_q[0].whi) m_hi = m_q[0].res[63:32];
          if (m_q[0].wlo) m_lo = m_q[0].res[31:0];
          void'(m_q.pop_front());
        end
        if (m_busy && dd) begin
          m_lo = qt; m_hi = rm; m_busy = 1'b0;
        end
      end
      if (acc) begin
        if (is_mul) m_q.push_back('{cyc + 2, product(op, a, b), 1'b1, 1'b1});
        if (is_div) m_busy = 1'b1;
        if (op == 3'd5) begin
          foreach (m_q[i]) m_q[i].whi = 1'b0;
          m_hi = a;
        end
        if (op == 3'd6) begin
          foreach (m_q[i]) m_q[i].wlo = 1'b0;
          m_lo = a;
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
  endtask

  task automatic op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    cycle(1'b1, o, a, b, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
  endtask

  initial begin
    bit          v, fl, dd, rn;
    logic [2:0]  o;
    logic [31:0] a, b;
    cyc = 0; m_hi = 32'd0; m_lo = 32'd0; m_busy = 1'b0;
    rst_n = 1'b0; flush_i = 1'b0; op_valid_i = 1'b0; op_i = 3'd0;
    opr1_i = 32'd0; opr2_i = 32'd0; div_done_i = 1'b0;
    div_quot_i = 32'd0; div_rem_i = 32'd0; mul_res_i = 64'd0;
    @(posedge clk); #1;

    // Reset with a multiply offered: no start, ready high, idle outputs.
    cycle(1'b1, 3'd1, 32'd5, 32'd6, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    idle(1);

    // Signed multiply -2 * 3.
    op(3'd1, 32'hFFFF_FFFE, 32'd3);
    idle(2);
    check("r23_hi", hi_o, 32'hFFFF_FFFF);
    check("r23_lo", lo_o, 32'hFFFF_FFFA);
    idle(1);

    // Back-to-back unsigned multiplies retire in order.
    op(3'd2, 32'h0001_0000, 32'h0001_0000);
    op(3'd2, 32'hFFFF_FFFF, 32'd2);
    idle(1);
    check("r24_hi_c3", hi_o, 32'd1);
    check("r24_lo_c3", lo_o, 32'd0);
    idle(1);
    check("r24_hi_c4", hi_o, 32'd1);
    check("r24_lo_c4", lo_o, 32'hFFFF_FFFE);

    // MTHI after a multiply overrides the multiply's HI write.
    op(3'd1, 32'd5, 32'd7);
    op(3'd5, 32'h0000_1234, 32'd0);
    idle(2);
    check("r25_hi", hi_o, 32'h0000_1234);
    check("r25_lo", lo_o, 32'd35);

    // Signed divide 7 / -2 with a 33-cycle divider.
    op(3'd3, 32'd7, 32'hFFFF_FFFE);
    idle(33);
    cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b1);
    check("r26_lo", lo_o, 32'hFFFF_FFFD);
    check("r26_hi", hi_o, 32'd1);
    check("r26_div_active", mdu_div_active, 1'b0);

    // Flush cancels an in-flight divide; results untouched.
    op(3'd4, 32'd100, 32'd9);
    idle(3);
    cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1);
    check("r27_hi", hi_o, 32'd1);
    check("r27_lo", lo_o, 32'hFFFF_FFFD);
    check("r27_div_active", mdu_div_active, 1'b0);
    idle(1);

    // Divide offered while a multiply is in the tracker is refused.
    op(3'd2, 32'd3, 32'd4);
    op(3'd3, 32'd8, 32'd2);
    check("r27_ready", last_ready, 1'b0);
    check("r27_nostart", last_div_start, 1'b0);
    idle(3);

    // Reset during a divide, later done pulse ignored.
    op(3'd3, 32'd50, 32'd5);
    idle(5);
    cycle(1'b1, 3'd1, 32'd9, 32'd9, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h0000_AAAA, 32'h0000_BBBB, 1'b1);
    check("r28_hi", hi_o, 32'd0);
    check("r28_lo", lo_o, 32'd0);
    check("r28_div_active", mdu_div_active, 1'b0);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      o  = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      fl = ($urandom_range(0, 11) == 0);
      dd = m_busy ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 9) == 0);
      rn = ($urandom_range(0, 199) != 0);
      cycle(v, o, a, b, fl, dd, $urandom, $urandom, rn);
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
